// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO with memory-mapped drain window
// and a programmable fill-level interrupt.
module uart_rx_fifo #(
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] BASE_ADDR = 32'hffff0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_frame_err,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    output logic        irq
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;
    localparam int CMPW  = (CW > 5) ? CW : 5;

    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_n;
    logic              overflow, overflow_n;
    logic              enable, enable_n;
    logic              irq_en, irq_en_n;
    logic [4:0]        thresh, thresh_n;
    logic              irq_n;

    logic        hit, sel_data, sel_stat, sel_ctrl;
    logic        empty, full, push, pop, ovf_set;
    logic        ctrl_wr, stat_wr, flush;
    logic [31:0] rdata;
    logic        unused;

    assign hit      = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign sel_data = hit && (mem_addr[3:0] == 4'h0);
    assign sel_stat = hit && (mem_addr[3:0] == 4'h4);
    assign sel_ctrl = hit && (mem_addr[3:0] == 4'h8);

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = mem_re & ~mem_we & sel_data & ~empty;
    assign push    = rx_valid & enable & (~full | pop);
    assign ovf_set = rx_valid & enable & full & ~pop;
    assign ctrl_wr = mem_we & sel_ctrl;
    assign stat_wr = mem_we & sel_stat;
    assign flush   = ctrl_wr & mem_data[1];

    assign unused = ^{mem_data[31:13], mem_data[7:3]};

    // Next-state for occupancy, sticky overflow and control fields
    always_comb begin
        count_n    = count;
        overflow_n = overflow;
        enable_n   = enable;
        irq_en_n   = irq_en;
        thresh_n   = thresh;
        if (push && !pop)
            count_n = count + 1'b1;
        else if (pop && !push)
            count_n = count - 1'b1;
        if (stat_wr && mem_data[2])
            overflow_n = 1'b0;
        if (ovf_set)
            overflow_n = 1'b1;
        if (ctrl_wr) begin
            enable_n = mem_data[0];
            irq_en_n = mem_data[2];
            thresh_n = mem_data[12:8];
        end
        if (flush) begin
            count_n    = '0;
            overflow_n = 1'b0;
        end
        irq_n = irq_en_n & (CMPW'(count_n) >= CMPW'(thresh_n));
    end

    // Pointer, status and control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            thresh   <= '0;
            irq      <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_n;
            overflow <= overflow_n;
            enable   <= enable_n;
            irq_en   <= irq_en_n;
            thresh   <= thresh_n;
            irq      <= irq_n;
        end
    end

    // Storage array; contents are don't-care after reset or flush
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {rx_frame_err, rx_data};
    end

    // Combinational register read mux
    always_comb begin
        rdata = '0;
        if (sel_data) begin
            if (empty)
                rdata[31] = 1'b1;
            else
                rdata[8:0] = mem[rd_ptr];
        end else if (sel_stat) begin
            rdata[0]      = empty;
            rdata[1]      = full;
            rdata[2]      = overflow;
            rdata[8 +: CW] = count;
        end else if (sel_ctrl) begin
            rdata[0]    = enable;
            rdata[2]    = irq_en;
            rdata[12:8] = thresh;
        end
    end

    assign mem_data = (!mem_we && hit) ? rdata : 32'bz;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios
// plus randomized traffic against a queue-based model.
module tb_uart_rx_fifo;

    localparam logic [31:0] BASE  = 32'hffff0040;
    localparam logic [31:0] A_DAT = BASE;
    localparam logic [31:0] A_STA = BASE + 32'h4;
    localparam logic [31:0] A_CTL = BASE + 32'h8;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_frame_err = 1'b0;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] wdata = '0;
    wire  [31:0] mem_data;
    logic        irq;

    assign mem_data = mem_we ? wdata : 32'bz;

    uart_rx_fifo #(.ADDR_W(4), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .rst(rst),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_frame_err(rx_frame_err),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [8:0] q[$];
    logic       m_ovf, m_en, m_ien;
    logic [4:0] m_th;

    function automatic void model_reset();
        q.delete();
        m_ovf = 0;
        m_en  = 0;
        m_ien = 0;
        m_th  = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a[3:0])
            4'h0: v = (q.size() == 0) ? 32'h8000_0000 : {23'b0, q[0]};
            4'h4: v = (q.size() << 8) | (32'(m_ovf) << 2)
                    | (32'(q.size() == DEPTH) << 1) | 32'(q.size() == 0);
            4'h8: v = {19'b0, m_th, 5'b0, m_ien, 1'b0, m_en};
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    function automatic logic model_irq();
        return m_ien && (q.size() >= int'(m_th));
    endfunction

    function automatic void model_update(
        input logic rxv, input logic [8:0] rxw, input logic we,
        input logic re, input logic [31:0] a, input logic [31:0] wd);
        logic was_full, popm, flush;
        was_full = (q.size() == DEPTH);
        popm = re && !we && (a == A_DAT) && (q.size() != 0);
        flush = we && (a == A_CTL) && wd[1];
        if (flush) begin
            q.delete();
            m_ovf = 0;
        end else begin
            if (we && a == A_STA && wd[2]) m_ovf = 0;
            if (popm) void'(q.pop_front());
            if (rxv && m_en) begin
                if (was_full && !popm) m_ovf = 1;
                else q.push_back(rxw);
            end
        end
        if (we && a == A_CTL) begin
            m_en  = wd[0];
            m_ien = wd[2];
            m_th  = wd[12:8];
        end
    endfunction

    // One bus/receiver cycle; returns bus value sampled mid-cycle
    task automatic drive_cycle(
        input logic rxv, input logic [7:0] d, input logic e,
        input logic we, input logic re, input logic [31:0] a,
        input logic [31:0] wd, output logic [31:0] rd);
        rx_valid = rxv;
        rx_data = d;
        rx_frame_err = e;
        mem_we = we;
        mem_re = re;
        mem_addr = a;
        wdata = wd;
        @(negedge clk);
        rd = mem_data;
        @(posedge clk);
        #1;
        model_update(rxv, {e, d}, we, re, a, wd);
        rx_valid = 0;
        mem_we = 0;
        mem_re = 0;
        mem_addr = 32'h0;
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        logic [31:0] r;
        drive_cycle(1, d, e, 0, 0, 32'h0, 0, r);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        drive_cycle(0, 0, 0, 0, (a == A_DAT), a, 0, v);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        drive_cycle(0, 0, 0, 1, 0, a, d, r);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_irq got %b want 0", irq);
        end
        rd(A_STA, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++;
            $display("FAIL reset_stat got %h want 00000001", v);
        end
        rd(A_CTL, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %h want 00000000", v);
        end
        rd(A_DAT, v);
        n_cmp++;
        if (v !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL reset_data got %h want 80000000", v);
        end
    endtask

    task automatic test_ordering();
        logic [31:0] v;
        logic [31:0] exp [3];
        exp[0] = 32'h041;
        exp[1] = 32'h142;
        exp[2] = 32'h043;
        wr(A_CTL, 32'h1);
        push(8'h41, 0);
        push(8'h42, 1);
        push(8'h43, 0);
        rd(A_STA, v);
        n_cmp++;
        if (v !== 32'h300) begin
            n_bad++;
            $display("FAIL order_stat got %h want 00000300", v);
        end
        for (int i = 0; i < 3; i++) begin
            rd(A_DAT, v);
            n_cmp++;
            if (v !== exp[i]) begin
                n_bad++;
                $display("FAIL order_data%0d got %h want %h", i, v, exp[i]);
            end
        end
        rd(A_STA, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++;
            $display("FAIL order_empty got %h want 00000001", v);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        for (int i = 0; i < 16; i++) push(8'(i), 0);
        push(8'hFF, 0);
        rd(A_STA, v);
        n_cmp++;
        if (v !== 32'h1006) begin
            n_bad++;
            $display("FAIL ovf_stat got %h want 00001006", v);
        end
        for (int i = 0; i < 16; i++) begin
            rd(A_DAT, v);
            n_cmp++;
            if (v !== 32'(i)) begin
                n_bad++;
                $display("FAIL ovf_drain%0d got %h want %h", i, v, 32'(i));
            end
        end
        rd(A_STA, v);
        n_cmp++;
        if (v !== 32'h5) begin
            n_bad++;
            $display("FAIL ovf_sticky got %h want 00000005", v);
        end
        wr(A_STA, 32'h4);
        rd(A_STA, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++;
            $display("FAIL ovf_clear got %h want 00000001", v);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] v;
        for (int i = 0; i < 16; i++) push(8'(i), 0);
        drive_cycle(1, 8'hAA, 0, 0, 1, A_DAT, 0, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_bad++;
            $display("FAIL fpp_read got %h want 00000000", v);
        end
        rd(A_STA, v);
        n_cmp++;
        if (v !== 32'h1002) begin
            n_bad++;
            $display("FAIL fpp_stat got %h want 00001002", v);
        end
        for (int i = 1; i < 16; i++) rd(A_DAT, v);
        rd(A_DAT, v);
        n_cmp++;
        if (v !== 32'hAA) begin
            n_bad++;
            $display("FAIL fpp_last got %h want 000000aa", v);
        end
    endtask

    task automatic test_flush_race();
        logic [31:0] v;
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i), 0);
        drive_cycle(1, 8'h77, 0, 1, 0, A_CTL, 32'h3, v);
        rd(A_STA, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++;
            $display("FAIL flush_stat got %h want 00000001", v);
        end
        rd(A_CTL, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++;
            $display("FAIL flush_ctrl got %h want 00000001", v);
        end
        push(8'h5A, 0);
        rd(A_DAT, v);
        n_cmp++;
        if (v !== 32'h5A) begin
            n_bad++;
            $display("FAIL flush_after got %h want 0000005a", v);
        end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        wr(A_CTL, 32'h0405);
        for (int i = 0; i < 3; i++) begin
            push(8'(i), 0);
            n_cmp++;
            if (irq !== 1'b0) begin
                n_bad++;
                $display("FAIL irq_below%0d got %b want 0", i, irq);
            end
        end
        push(8'h3, 0);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_at_thresh got %b want 1", irq);
        end
        rd(A_DAT, v);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_after_pop got %b want 0", irq);
        end
        wr(A_CTL, 32'h0007);
        wr(A_CTL, 32'h0005);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_thresh0 got %b want 1", irq);
        end
        wr(A_CTL, 32'h1105);
        for (int i = 0; i < 16; i++) push(8'(i), 0);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_thresh17 got %b want 0", irq);
        end
        wr(A_CTL, 32'h0);
        push(8'hEE, 0);
        rd(A_STA, v);
        n_cmp++;
        if (v !== 32'h1002) begin
            n_bad++;
            $display("FAIL disabled_stat got %h want 00001002", v);
        end
        wr(A_CTL, 32'h3);
    endtask

    task automatic test_random();
        logic [31:0] v, exp, a, wd;
        logic        rxv, we, re;
        int          r;
        for (int c = 0; c < 800; c++) begin
            r   = $urandom_range(0, 99);
            rxv = ($urandom_range(0, 99) < 55);
            we  = 0;
            re  = 0;
            wd  = 0;
            if (r < 40) begin
                a = A_DAT;
                re = ($urandom_range(0, 3) != 0);
            end else if (r < 52) begin
                a = A_STA;
                re = 1;
            end else if (r < 58) begin
                a = A_CTL;
                re = 1;
            end else if (r < 62) begin
                a = A_STA;
                we = 1;
                wd = $urandom;
            end else if (r < 66) begin
                a = A_CTL;
                we = 1;
                wd = {19'b0, 5'($urandom_range(0, 20)), 5'b0,
                      1'($urandom), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 4) != 0)};
            end else begin
                a = BASE + {28'b0, 4'($urandom_range(0, 15))};
            end
            exp = model_read(a);
            drive_cycle(rxv, 8'($urandom), 1'($urandom), we, re, a, wd, v);
            if (!we) begin
                n_cmp++;
                if (v !== exp) begin
                    n_bad++;
                    $display("FAIL rand_read c=%0d a=%h got %h want %h",
                             c, a, v, exp);
                end
            end
            n_cmp++;
            if (irq !== model_irq()) begin
                n_bad++;
                $display("FAIL rand_irq c=%0d got %b want %b",
                         c, irq, model_irq());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(A_CTL, 32'h0105);
        push(8'h11, 0);
        push(8'h22, 0);
        test_reset();
        push(8'h33, 0);
        rd(A_STA, v);
        n_cmp++;
        if (v !== 32'h1) begin
            n_bad++;
            $display("FAIL midreset_disabled got %h want 00000001", v);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ordering();
        test_overflow();
        test_full_push_pop();
        test_flush_race();
        test_irq();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
